// File: rtl/video_timing_paddle.sv
// video_timing_paddle: pixel-clock divider, parametrised VGA/HDMI raster timing and player paddle.
// Optional macro PADDLE_ACCEL_EN: paddle step doubles after 8 consecutive same-direction frames.
module video_timing_paddle #(
  parameter int          CLK_DIV   = 2,
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter logic        HS_POL    = 1'b0,
  parameter logic        VS_POL    = 1'b0,
  parameter int          PAD_W     = 64,
  parameter int          PAD_H     = 16,
  parameter int          PAD_STEP  = 4,
  parameter logic [23:0] PAD_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR  = 24'h000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        restart,
  input  logic        to_left,
  input  logic        to_right,
  output logic        pix_ce,
  output logic        hdmi_hs,
  output logic        hdmi_vs,
  output logic        hdmi_de,
  output logic [23:0] hdmi_data,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start,
  output logic [11:0] pad_x
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [11:0] PAD_INIT = 12'((H_ACTIVE - PAD_W) / 2);
  localparam logic [11:0] PAD_MAX  = 12'(H_ACTIVE - PAD_W);

  logic [DIV_W-1:0]   div_r, div_next_s;
  logic [11:0]        h_cnt_r, v_cnt_r, h_next_s, v_next_s;
  logic               left_meta_r, left_sync_r, right_meta_r, right_sync_r;
  logic               frame_tick_s, move_left_s, move_right_s;
  logic               de_s, pad_hit_s;
  logic [11:0]        x_s, y_s;
  logic signed [12:0] step_s, pad_cur_s, pad_try_s;
  logic [11:0]        pad_next_s;

  // Divider and raster counter next-state
  always_comb begin
    div_next_s = (div_r == DIV_LAST) ? {DIV_W{1'b0}} : div_r + DIV_W'(1);
    h_next_s   = (h_cnt_r == 12'(H_TOTAL - 1)) ? 12'd0 : h_cnt_r + 12'd1;
    if (h_cnt_r == 12'(H_TOTAL - 1)) begin
      v_next_s = (v_cnt_r == 12'(V_TOTAL - 1)) ? 12'd0 : v_cnt_r + 12'd1;
    end else begin
      v_next_s = v_cnt_r;
    end
  end

  // Timing decode of the counter value presented this pixel
  always_comb begin
    de_s = (h_cnt_r >= 12'(H_START)) && (h_cnt_r < 12'(H_START + H_ACTIVE)) &&
           (v_cnt_r >= 12'(V_START)) && (v_cnt_r < 12'(V_START + V_ACTIVE));
    x_s  = h_cnt_r - 12'(H_START);
    y_s  = v_cnt_r - 12'(V_START);
    if (de_s) begin
      pad_hit_s = ({1'b0, x_s} >= {1'b0, pad_x}) &&
                  ({1'b0, x_s} < ({1'b0, pad_x} + 13'(PAD_W))) &&
                  (y_s >= 12'(V_ACTIVE - PAD_H));
    end else begin
      pad_hit_s = 1'b0;
    end
  end

  // Pixel divider; pix_ce is registered so it is high exactly while div_r == CLK_DIV-1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_r  <= {DIV_W{1'b0}};
      pix_ce <= 1'b0;
    end else if (restart) begin
      div_r  <= {DIV_W{1'b0}};
      pix_ce <= 1'b0;
    end else begin
      div_r  <= div_next_s;
      pix_ce <= (div_next_s == DIV_LAST);
    end
  end

  // Raster counters and registered video outputs, advanced once per pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_r     <= 12'd0;
      v_cnt_r     <= 12'd0;
      hdmi_hs     <= ~HS_POL;
      hdmi_vs     <= ~VS_POL;
      hdmi_de     <= 1'b0;
      hdmi_data   <= 24'd0;
      pix_x       <= 12'd0;
      pix_y       <= 12'd0;
      frame_start <= 1'b0;
    end else if (restart) begin
      h_cnt_r     <= 12'd0;
      v_cnt_r     <= 12'd0;
      hdmi_hs     <= ~HS_POL;
      hdmi_vs     <= ~VS_POL;
      hdmi_de     <= 1'b0;
      hdmi_data   <= 24'd0;
      pix_x       <= 12'd0;
      pix_y       <= 12'd0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      h_cnt_r     <= h_next_s;
      v_cnt_r     <= v_next_s;
      hdmi_hs     <= (h_cnt_r < 12'(H_SYNC)) ? HS_POL : ~HS_POL;
      hdmi_vs     <= (v_cnt_r < 12'(V_SYNC)) ? VS_POL : ~VS_POL;
      hdmi_de     <= de_s;
      hdmi_data   <= de_s ? (pad_hit_s ? PAD_COLOR : BG_COLOR) : 24'd0;
      pix_x       <= de_s ? x_s : 12'd0;
      pix_y       <= de_s ? y_s : 12'd0;
      frame_start <= (h_cnt_r == 12'd0) && (v_cnt_r == 12'd0);
    end else begin
      h_cnt_r     <= h_cnt_r;
      v_cnt_r     <= v_cnt_r;
    end
  end

  // Two-flop synchronisers for the asynchronous buttons
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_meta_r  <= 1'b0;
      left_sync_r  <= 1'b0;
      right_meta_r <= 1'b0;
      right_sync_r <= 1'b0;
    end else if (restart) begin
      left_meta_r  <= 1'b0;
      left_sync_r  <= 1'b0;
      right_meta_r <= 1'b0;
      right_sync_r <= 1'b0;
    end else begin
      left_meta_r  <= to_left;
      left_sync_r  <= left_meta_r;
      right_meta_r <= to_right;
      right_sync_r <= right_meta_r;
    end
  end

  assign frame_tick_s = pix_ce && (h_cnt_r == 12'd0) && (v_cnt_r == 12'd0);
  assign move_left_s  = left_sync_r && !right_sync_r;
  assign move_right_s = right_sync_r && !left_sync_r;

`ifdef PADDLE_ACCEL_EN
  logic [3:0] run_r;
  logic       run_right_r;

  // Step doubles once the same-direction run has saturated
  always_comb begin
    if (run_r == 4'd8) begin
      step_s = 13'(2 * PAD_STEP);
    end else begin
      step_s = 13'(PAD_STEP);
    end
  end

  // Consecutive same-direction frame counter; a reversal starts a fresh run
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_r       <= 4'd0;
      run_right_r <= 1'b0;
    end else if (restart) begin
      run_r       <= 4'd0;
      run_right_r <= 1'b0;
    end else if (frame_tick_s) begin
      if (move_left_s || move_right_s) begin
        if ((run_r != 4'd0) && (run_right_r == move_right_s)) begin
          run_r <= (run_r == 4'd8) ? 4'd8 : run_r + 4'd1;
        end else begin
          run_r <= 4'd1;
        end
        run_right_r <= move_right_s;
      end else begin
        run_r <= 4'd0;
      end
    end else begin
      run_r <= run_r;
    end
  end
`else
  assign step_s = 13'(PAD_STEP);
`endif

  // Clamped paddle move; signed 13-bit so a left step never wraps below zero
  always_comb begin
    pad_cur_s  = $signed({1'b0, pad_x});
    pad_try_s  = pad_cur_s;
    pad_next_s = pad_x;
    if (move_left_s) begin
      pad_try_s  = pad_cur_s - step_s;
      pad_next_s = (pad_try_s < 13'sd0) ? 12'd0 : pad_try_s[11:0];
    end else if (move_right_s) begin
      pad_try_s  = pad_cur_s + step_s;
      pad_next_s = (pad_try_s > $signed({1'b0, PAD_MAX})) ? PAD_MAX : pad_try_s[11:0];
    end else begin
      pad_next_s = pad_x;
    end
  end

  // Paddle position only changes at the frame-start pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pad_x <= PAD_INIT;
    end else if (restart) begin
      pad_x <= PAD_INIT;
    end else if (frame_tick_s) begin
      pad_x <= pad_next_s;
    end else begin
      pad_x <= pad_x;
    end
  end

endmodule

// File: tb/tb_video_timing_paddle.sv
// Self-checking bench for video_timing_paddle with a reduced raster so many frames fit in a short run.
module tb_video_timing_paddle;

  localparam int CD = 2;
  localparam int HA = 16, HF = 2, HS = 3, HB = 2;
  localparam int VA = 8, VF = 1, VS = 1, VB = 1;
  localparam int PW = 4, PH = 2, PS = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FR = HT * VT;
  localparam int PAD0 = (HA - PW) / 2;
  localparam int PMAX = HA - PW;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        restart = 1'b0;
  logic        to_left = 1'b0;
  logic        to_right = 1'b0;
  logic        pix_ce, hdmi_hs, hdmi_vs, hdmi_de, frame_start;
  logic [23:0] hdmi_data;
  logic [11:0] pix_x, pix_y, pad_x;
  logic [64:0] dut_vec;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int pad_m = PAD0;
  int run_m = 0;
  bit run_right_m = 1'b0;

  video_timing_paddle #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PAD_W(PW), .PAD_H(PH), .PAD_STEP(PS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .restart(restart), .to_left(to_left), .to_right(to_right),
    .pix_ce(pix_ce), .hdmi_hs(hdmi_hs), .hdmi_vs(hdmi_vs), .hdmi_de(hdmi_de),
    .hdmi_data(hdmi_data), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .pad_x(pad_x)
  );

  always #5 clk = ~clk;

  assign dut_vec = {hdmi_hs, hdmi_vs, hdmi_de, hdmi_data, pix_x, pix_y, frame_start, pad_x, pix_ce};

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference: n clock edges since reset/restart -> n/CD pixels emitted; output shows pixel index n/CD-1.
  function automatic logic [64:0] model_vec();
    int p, q, h, v, x, y;
    logic hs, vs, de, fs, ce;
    logic [23:0] d;
    p  = n / CD;
    ce = ((n % CD) == CD - 1);
    if (p == 0) return {1'b1, 1'b1, 1'b0, 24'h0, 12'h0, 12'h0, 1'b0, 12'(pad_m), ce};
    q  = p - 1;
    h  = q % HT;
    v  = (q / HT) % VT;
    hs = (h < HS) ? 1'b0 : 1'b1;
    vs = (v < VS) ? 1'b0 : 1'b1;
    de = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    x  = de ? h - (HS + HB) : 0;
    y  = de ? v - (VS + VB) : 0;
    fs = (h == 0) && (v == 0);
    if (!de) d = 24'h000000;
    else if (x >= pad_m && x < pad_m + PW && y >= VA - PH) d = 24'hFFFFFF;
    else d = 24'h000000;
    return {hs, vs, de, d, 12'(x), 12'(y), fs, 12'(pad_m), ce};
  endfunction

  // Paddle update applied by the model at every frame start.
  task automatic frame_update();
    int stp;
    bit l, r;
    l = to_left;
    r = to_right;
`ifdef PADDLE_ACCEL_EN
    stp = (run_m >= 8) ? 2 * PS : PS;
`else
    stp = PS;
`endif
    if (l && !r) pad_m = (pad_m - stp < 0) ? 0 : pad_m - stp;
    else if (r && !l) pad_m = (pad_m + stp > PMAX) ? PMAX : pad_m + stp;
    if (l != r) begin
      run_m = (run_m > 0 && run_right_m == r) ? ((run_m >= 8) ? 8 : run_m + 1) : 1;
      run_right_m = r;
    end else begin
      run_m = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset_n || restart) begin
      n = 0; pad_m = PAD0; run_m = 0;
    end else begin
      n++;
      if ((n % CD) == 0 && ((n / CD) - 1) % FR == 0) frame_update();
    end
    @(negedge clk);
  endtask

  // Buttons only change well away from a frame-start sample.
  function automatic bit safe();
    int qf;
    if (n / CD < 1) return 1'b0;
    qf = ((n / CD) - 1) % FR;
    return (qf >= 3) && (qf <= FR - 5);
  endfunction

  task automatic set_buttons(input bit l, input bit r);
    int k;
    k = 0;
    while (!safe() && k < 2 * FR * CD) begin step(); k++; end
    checks++;
    if (!safe()) begin errors++; $display("FAIL set_buttons timeout got %0d want safe", n); end
    to_left = l;
    to_right = r;
  endtask

  task automatic goto_h12_v5();
    int k, q;
    k = 0;
    q = n / CD - 1;
    while (!(q >= 0 && (n % CD) == 0 && q % HT == 12 && (q / HT) % VT == 5) && k < 2 * FR * CD) begin
      step(); k++; q = n / CD - 1;
    end
    checks++;
    if (k >= 2 * FR * CD) begin errors++; $display("FAIL goto_h12_v5 timeout got %0d want position", n); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec !== model_vec()) begin errors++; $display("FAIL reset_state got %h want %h", dut_vec, model_vec()); end
    checks++;
    if (pad_x !== 12'd6) begin errors++; $display("FAIL reset_pad got %0d want 6", pad_x); end
    reset_n = 1'b1;
    for (int i = 0; i < FR * CD + 4; i++) begin
      step(); checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL first_frame clk %0d got %h want %h", i, dut_vec, model_vec()); end
    end
  endtask

  task automatic test_timing();
    int k, clk_cnt, de_cnt, hs_cnt, vs_cnt;
    bit prev;
    k = 0;
    while (frame_start !== 1'b0 && k < 2 * FR * CD) begin step(); k++; end
    while (frame_start !== 1'b1 && k < 2 * FR * CD) begin step(); k++; end
    clk_cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    prev = 1'b1;
    do begin
      de_cnt += int'(hdmi_de); hs_cnt += int'(!hdmi_hs); vs_cnt += int'(!hdmi_vs); clk_cnt++;
      prev = frame_start;
      step();
    end while (!(frame_start === 1'b1 && prev == 1'b0) && clk_cnt < 2 * FR * CD);
    checks++;
    if (clk_cnt != FR * CD) begin errors++; $display("FAIL frame_len got %0d want %0d", clk_cnt, FR * CD); end
    checks++;
    if (de_cnt != HA * VA * CD) begin errors++; $display("FAIL de_count got %0d want %0d", de_cnt, HA * VA * CD); end
    checks++;
    if (hs_cnt != HS * VT * CD) begin errors++; $display("FAIL hs_count got %0d want %0d", hs_cnt, HS * VT * CD); end
    checks++;
    if (vs_cnt != VS * HT * CD) begin errors++; $display("FAIL vs_count got %0d want %0d", vs_cnt, VS * HT * CD); end
  endtask

  task automatic test_paddle_moves();
    set_buttons(1'b0, 1'b1);
    for (int i = 0; i < 10 * FR * CD; i++) begin
      step(); checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL right_hold clk %0d got %h want %h", i, dut_vec, model_vec()); end
    end
    checks++;
    if (pad_x !== 12'd12) begin errors++; $display("FAIL right_clamp got %0d want 12", pad_x); end
    set_buttons(1'b1, 1'b0);
    for (int i = 0; i < 10 * FR * CD; i++) begin
      step(); checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL left_hold clk %0d got %h want %h", i, dut_vec, model_vec()); end
    end
    checks++;
    if (pad_x !== 12'd0) begin errors++; $display("FAIL left_clamp got %0d want 0", pad_x); end
  endtask

  task automatic test_both_held();
    set_buttons(1'b0, 1'b1);
    for (int i = 0; i < 2 * FR * CD; i++) step();
    set_buttons(1'b1, 1'b1);
    for (int i = 0; i < 5 * FR * CD; i++) begin
      step(); checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL both_hold clk %0d got %h want %h", i, dut_vec, model_vec()); end
    end
    checks++;
    if (pad_x !== 12'd4) begin errors++; $display("FAIL both_pad got %0d want 4", pad_x); end
  endtask

  task automatic test_random_buttons();
    for (int i = 0; i < 15 * FR * CD; i++) begin
      step(); checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL random clk %0d got %h want %h", i, dut_vec, model_vec()); end
      if (safe() && $urandom_range(0, 99) < 3) begin
        to_left = 1'($urandom);
        to_right = 1'($urandom);
      end
    end
    set_buttons(1'b0, 1'b0);
  endtask

  task automatic test_restart();
    goto_h12_v5();
    restart = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL restart_idle clk %0d got %h want %h", i, dut_vec, model_vec()); end
    end
    checks++;
    if (pad_x !== 12'd6 || hdmi_hs !== 1'b1 || hdmi_vs !== 1'b1 || hdmi_de !== 1'b0) begin
      errors++; $display("FAIL restart_state got %h want pad 6 hs 1 vs 1 de 0", dut_vec);
    end
    restart = 1'b0;
    for (int i = 0; i < FR * CD + 6; i++) begin
      step(); checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL after_restart clk %0d got %h want %h", i, dut_vec, model_vec()); end
    end
  endtask

  task automatic test_async_reset();
    set_buttons(1'b0, 1'b1);
    for (int i = 0; i < 2 * FR * CD; i++) step();
    set_buttons(1'b0, 1'b0);
    goto_h12_v5();
    #2;
    reset_n = 1'b0;
    n = 0; pad_m = PAD0; run_m = 0;
    #1;
    checks++;
    if (dut_vec !== model_vec()) begin errors++; $display("FAIL async_reset got %h want %h", dut_vec, model_vec()); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < FR * CD + 6; i++) begin
      step(); checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL after_reset clk %0d got %h want %h", i, dut_vec, model_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_paddle_moves();
    test_both_held();
    test_random_buttons();
    test_restart();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
